// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of the APB master command channel.
// Latches one requester's command, holds trnsfr until the APB access
// completes or the watchdog expires, then returns data/status to the owner.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

module apb_req_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned AW      = `ADDR_WIDTH,
   parameter int unsigned DW      = `DATA_WIDTH,
   parameter int unsigned SW      = `STRB_SIZE,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester side
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   input  logic [NUM_REQ*SW-1:0] req_strb,
   input  logic [NUM_REQ*2-1:0]  req_dsel,
   output logic [NUM_REQ-1:0]    req_grant,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [1:0]            owner,
   // APB master command channel
   output logic                  trnsfr,
   output logic                  wr,
   output logic [AW-1:0]         address,
   output logic [DW-1:0]         data_in,
   output logic [SW-1:0]         strb,
   output logic [1:0]            dsel,
   input  logic [DW-1:0]         data_out,
   // observed APB phase signals
   input  logic                  sel,
   input  logic                  enable,
   input  logic                  ready,
   input  logic                  slverr
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Elaboration-time guard on the supported requester count
   generate
      if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
         $error("apb_req_arbiter: NUM_REQ must be in 2..4");
      end
   endgenerate

   logic [0:0]         state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [CW-1:0]      wd_cnt_q, wd_cnt_d;

   logic               found_c;
   logic [1:0]         win_c;
   int                 idx_c;

   logic               sel_wr_c;
   logic [AW-1:0]      sel_addr_c;
   logic [DW-1:0]      sel_wdata_c;
   logic [SW-1:0]      sel_strb_c;
   logic [1:0]         sel_dsel_c;

   logic               complete_c;
   logic               timeout_c;

   logic [NUM_REQ-1:0] grant_d, done_d;
   logic [DW-1:0]      rdata_d;
   logic               err_d, busy_d, trnsfr_d, wr_d;
   logic [1:0]         owner_d, dsel_d;
   logic [AW-1:0]      addr_d;
   logic [DW-1:0]      wdata_d;
   logic [SW-1:0]      strb_d;

   // Round-robin winner: first valid requester searching upward from ptr
   always_comb begin
      found_c = 1'b0;
      win_c   = 2'd0;
      idx_c   = 0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx_c = int'(ptr_q) + k;
         if (idx_c >= int'(NUM_REQ)) idx_c = idx_c - int'(NUM_REQ);
         if (req_valid[IW'(idx_c)]) begin
            found_c = 1'b1;
            win_c   = 2'(idx_c);
         end
      end
   end

   // Command mux for the winning requester
   always_comb begin
      sel_wr_c    = 1'b0;
      sel_addr_c  = '0;
      sel_wdata_c = '0;
      sel_strb_c  = '0;
      sel_dsel_c  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win_c == 2'(i)) begin
            sel_wr_c    = req_wr[i];
            sel_addr_c  = req_addr[i*AW +: AW];
            sel_wdata_c = req_wdata[i*DW +: DW];
            sel_strb_c  = req_strb[i*SW +: SW];
            sel_dsel_c  = req_dsel[i*2 +: 2];
         end
      end
   end

   // Completion and watchdog-expiry qualifiers for the current BUSY cycle
   always_comb begin
      complete_c = sel & enable & ready;
      timeout_c  = (TIMEOUT != 0) && ((wd_cnt_q + CW'(1)) == CW'(TIMEOUT));
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wd_cnt_d = wd_cnt_q;
      grant_d  = '0;
      done_d   = '0;
      rdata_d  = rsp_rdata;
      err_d    = rsp_err;
      busy_d   = busy;
      owner_d  = owner;
      trnsfr_d = trnsfr;
      wr_d     = wr;
      addr_d   = address;
      wdata_d  = data_in;
      strb_d   = strb;
      dsel_d   = dsel;

      case (state_q)
         ST_IDLE: begin
            if (found_c) begin
               state_d  = ST_BUSY;
               ptr_d    = (int'(win_c) + 1 >= int'(NUM_REQ)) ? 2'd0 : win_c + 2'd1;
               wd_cnt_d = '0;
               grant_d  = NUM_REQ'(1) << win_c;
               owner_d  = win_c;
               busy_d   = 1'b1;
               trnsfr_d = 1'b1;
               wr_d     = sel_wr_c;
               addr_d   = sel_addr_c;
               wdata_d  = sel_wdata_c;
               strb_d   = sel_strb_c;
               dsel_d   = sel_dsel_c;
            end
         end
         ST_BUSY: begin
            if (complete_c || timeout_c) begin
               state_d  = ST_IDLE;
               trnsfr_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = NUM_REQ'(1) << owner;
               // a real completion takes priority over a coincident timeout
               if (complete_c) begin
                  err_d   = slverr;
                  rdata_d = wr ? '0 : data_out;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end else if (TIMEOUT != 0) begin
               wd_cnt_d = wd_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, pointer, watchdog and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         wd_cnt_q  <= '0;
         req_grant <= '0;
         req_done  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         owner     <= 2'd0;
         trnsfr    <= 1'b0;
         wr        <= 1'b0;
         address   <= '0;
         data_in   <= '0;
         strb      <= '0;
         dsel      <= 2'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wd_cnt_q  <= wd_cnt_d;
         req_grant <= grant_d;
         req_done  <= done_d;
         rsp_rdata <= rdata_d;
         rsp_err   <= err_d;
         busy      <= busy_d;
         owner     <= owner_d;
         trnsfr    <= trnsfr_d;
         wr        <= wr_d;
         address   <= addr_d;
         data_in   <= wdata_d;
         strb      <= strb_d;
         dsel      <= dsel_d;
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small behavioural APB slave.
`timescale 1ns/1ps

module tb_apb_req_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned TO = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_wr = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR*SW-1:0] req_strb = '0;
   logic [NR*2-1:0]  req_dsel = '0;
   logic [NR-1:0]    req_grant, req_done;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err, busy;
   logic [1:0]       owner;
   logic             trnsfr, wr;
   logic [AW-1:0]    address;
   logic [DW-1:0]    data_in;
   logic [SW-1:0]    strb;
   logic [1:0]       dsel;
   logic [DW-1:0]    data_out;
   logic             sel, enable, ready, slverr;

   int checks = 0;
   int passes = 0;

   // slave model controls
   int          sl_wait  = 2;
   bit          sl_hang  = 1'b0;
   bit          sl_err   = 1'b0;
   logic [31:0] sl_rdata = 32'h0;
   int          phase    = 0;
   int          cnt      = 0;

   apb_req_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_dsel(req_dsel),
      .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .owner(owner),
      .trnsfr(trnsfr), .wr(wr), .address(address), .data_in(data_in),
      .strb(strb), .dsel(dsel), .data_out(data_out),
      .sel(sel), .enable(enable), .ready(ready), .slverr(slverr)
   );

   always #5 clk = ~clk;

   // APB slave: setup phase, then ready on the sl_wait-th enable cycle
   initial begin
      sel = 1'b0; enable = 1'b0; ready = 1'b0; slverr = 1'b0; data_out = '0;
      forever begin
         @(negedge clk);
         data_out = sl_rdata;
         if (phase != 0 && !trnsfr) begin
            sel = 1'b0; enable = 1'b0; ready = 1'b0; slverr = 1'b0; phase = 0;
         end else if (phase == 0) begin
            if (trnsfr) begin sel = 1'b1; phase = 1; end
         end else if (phase == 1) begin
            enable = 1'b1; cnt = 1; phase = 2;
            ready  = (cnt == sl_wait) && !sl_hang;
            slverr = ready && sl_err;
         end else begin
            cnt    = cnt + 1;
            ready  = (cnt == sl_wait) && !sl_hang;
            slverr = ready && sl_err;
         end
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin tick(); n++; end while (req_done == '0 && n < 40);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (trnsfr !== 1'b0 || busy !== 1'b0) $display("FAIL rst_trnsfr_busy: got %b%b want 00", trnsfr, busy); else passes++;
      checks++; if ({req_grant, req_done} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {req_grant, req_done}); else passes++;
      checks++; if ({wr, address, data_in, strb, dsel} !== '0) $display("FAIL rst_cmd: got %h want 0", {wr, address, data_in, strb, dsel}); else passes++;
      checks++; if ({rsp_rdata, rsp_err, owner} !== '0) $display("FAIL rst_rsp: got %h want 0", {rsp_rdata, rsp_err, owner}); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      int n, extra, held_bad;
      sl_wait = 2; sl_hang = 1'b0; sl_err = 1'b0; sl_rdata = 32'hA5A5_0001;
      req_wr = 2'b00; req_addr[31:0] = 32'h10; req_valid = 2'b01;
      tick();
      checks++; if (req_grant !== 2'b01) $display("FAIL rd_grant: got %b want 01", req_grant); else passes++;
      checks++; if (trnsfr !== 1'b1 || busy !== 1'b1) $display("FAIL rd_trnsfr: got %b%b want 11", trnsfr, busy); else passes++;
      checks++; if (address !== 32'h10 || wr !== 1'b0) $display("FAIL rd_cmd: got %h/%b want 00000010/0", address, wr); else passes++;
      // requester 1 asks while BUSY: must be ignored
      req_valid = 2'b10;
      n = 0; extra = 0; held_bad = 0;
      do begin
         tick(); n++;
         if (req_grant != '0) extra++;
         if (req_done == '0 && trnsfr !== 1'b1) held_bad++;
      end while (req_done == '0 && n < 40);
      req_valid = 2'b00;
      checks++; if (n !== 3) $display("FAIL rd_latency: got %0d want 3", n); else passes++;
      checks++; if (req_done !== 2'b01) $display("FAIL rd_done: got %b want 01", req_done); else passes++;
      checks++; if (rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0) $display("FAIL rd_rsp: got %h/%b want a5a50001/0", rsp_rdata, rsp_err); else passes++;
      checks++; if (trnsfr !== 1'b0 || busy !== 1'b0) $display("FAIL rd_end: got %b%b want 00", trnsfr, busy); else passes++;
      checks++; if (extra !== 0 || held_bad !== 0) $display("FAIL rd_busy_ignore: got %0d/%0d want 0/0", extra, held_bad); else passes++;
      tick();
      checks++; if (req_done !== 2'b00 || rsp_rdata !== 32'hA5A5_0001) $display("FAIL rd_hold: got %b/%h want 00/a5a50001", req_done, rsp_rdata); else passes++;
   endtask

   task automatic test_contention();
      int g, d;
      logic [1:0]  exp_g;
      logic [31:0] exp_a;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      sl_wait = 1; sl_err = 1'b0; sl_rdata = 32'h0000_0C0C;
      req_wr = 2'b00; req_addr = {32'h200, 32'h100}; req_valid = 2'b11;
      for (int t = 0; t < 8; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (t % 2 == 0) ? 32'h100 : 32'h200;
         g = 0;
         do begin tick(); g++; end while (req_grant == '0 && g < 40);
         if (t == 7) req_valid = 2'b00;
         checks++; if (req_grant !== exp_g) $display("FAIL cont_grant[%0d]: got %b want %b", t, req_grant, exp_g); else passes++;
         checks++; if (address !== exp_a) $display("FAIL cont_addr[%0d]: got %h want %h", t, address, exp_a); else passes++;
         checks++; if (g !== 1) $display("FAIL cont_gap[%0d]: got %0d want 1", t, g); else passes++;
         wait_done(d);
         checks++; if (req_done !== exp_g) $display("FAIL cont_done[%0d]: got %b want %b", t, req_done, exp_g); else passes++;
         checks++; if (trnsfr !== 1'b0) $display("FAIL cont_idle[%0d]: got %b want 0", t, trnsfr); else passes++;
      end
      tick();
      checks++; if (req_grant !== 2'b00) $display("FAIL cont_stop: got %b want 00", req_grant); else passes++;
   endtask

   task automatic test_write_error();
      int d;
      sl_wait = 2; sl_err = 1'b1; sl_rdata = 32'h1234_5678;
      req_wr = 2'b10; req_addr[63:32] = 32'h300; req_wdata[63:32] = 32'hDEAD_BEEF;
      req_strb[7:4] = 4'hC; req_dsel[3:2] = 2'b10; req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      checks++; if (req_grant !== 2'b10 || owner !== 2'd1) $display("FAIL wr_grant: got %b/%0d want 10/1", req_grant, owner); else passes++;
      checks++; if ({wr, address, data_in, strb, dsel} !== {1'b1, 32'h300, 32'hDEAD_BEEF, 4'hC, 2'b10})
         $display("FAIL wr_cmd: got %h want %h", {wr, address, data_in, strb, dsel}, {1'b1, 32'h300, 32'hDEAD_BEEF, 4'hC, 2'b10}); else passes++;
      wait_done(d);
      checks++; if (req_done !== 2'b10) $display("FAIL wr_done: got %b want 10", req_done); else passes++;
      checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL wr_rsp: got %b/%h want 1/00000000", rsp_err, rsp_rdata); else passes++;
      sl_err = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int d;
      sl_hang = 1'b1; sl_rdata = 32'h7777_7777;
      req_wr = 2'b00; req_addr[31:0] = 32'h40; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      checks++; if (req_grant !== 2'b01) $display("FAIL to_grant: got %b want 01", req_grant); else passes++;
      wait_done(d);
      checks++; if (d !== 8) $display("FAIL to_latency: got %0d want 8", d); else passes++;
      checks++; if (req_done !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL to_rsp: got %b/%b/%h want 01/1/00000000", req_done, rsp_err, rsp_rdata); else passes++;
      sl_hang = 1'b0; sl_wait = 2; sl_rdata = 32'h0000_55AA;
      tick();
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      checks++; if (req_grant !== 2'b01) $display("FAIL to_regrant: got %b want 01", req_grant); else passes++;
      wait_done(d);
      checks++; if (d !== 3 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_55AA) $display("FAIL to_after: got %0d/%b/%h want 3/0/000055aa", d, rsp_err, rsp_rdata); else passes++;
      tick();
   endtask

   task automatic test_same_cycle();
      int d;
      // ready lands on the watchdog cycle: completion must win
      sl_wait = 7; sl_err = 1'b0; sl_rdata = 32'hCAFE_0007;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      wait_done(d);
      checks++; if (d !== 8) $display("FAIL sc_latency: got %0d want 8", d); else passes++;
      checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_0007) $display("FAIL sc_rsp: got %b/%h want 0/cafe0007", rsp_err, rsp_rdata); else passes++;
      tick();
      // ready one cycle late: the watchdog fires first
      sl_wait = 8; sl_rdata = 32'hCAFE_0008;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      wait_done(d);
      checks++; if (d !== 8 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL sc_late: got %0d/%b/%h want 8/1/00000000", d, rsp_err, rsp_rdata); else passes++;
      tick();
   endtask

   task automatic test_reset_mid_busy();
      int d, stray;
      sl_hang = 1'b1;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      checks++; if (req_grant !== 2'b01) $display("FAIL mb_grant: got %b want 01", req_grant); else passes++;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++; if ({trnsfr, busy, owner, req_grant, req_done, rsp_err} !== '0) $display("FAIL mb_rst_ctl: got %b want 0", {trnsfr, busy, owner, req_grant, req_done, rsp_err}); else passes++;
      checks++; if ({wr, address, data_in, strb, dsel, rsp_rdata} !== '0) $display("FAIL mb_rst_data: got %h want 0", {wr, address, data_in, strb, dsel, rsp_rdata}); else passes++;
      stray = 0;
      tick(); if (req_done != '0) stray++;
      tick(); if (req_done != '0) stray++;
      sl_hang = 1'b0; sl_wait = 1; sl_rdata = 32'h0BAD_F00D;
      req_valid = 2'b11;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      req_valid = 2'b00;
      checks++; if (req_grant !== 2'b01) $display("FAIL mb_first: got %b want 01", req_grant); else passes++;
      checks++; if (stray !== 0) $display("FAIL mb_no_done: got %0d want 0", stray); else passes++;
      wait_done(d);
      checks++; if (req_done !== 2'b01 || rsp_rdata !== 32'h0BAD_F00D) $display("FAIL mb_after: got %b/%h want 01/0badf00d", req_done, rsp_rdata); else passes++;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_write_error();
      test_timeout();
      test_same_cycle();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
